skeleton_top: RTL and testbench

//  Single-cycle 32-bit processor top level with clock and reset as its only ports.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/regfile.sv | 81 ++++++++
 rtl/skeleton_top.sv | 110 +++++++++++
 tb/tb_skeleton_top.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core: opcode / aluop encodings,
// instruction field positions, special register indices and the decoder.
package cpu_pkg;
  localparam int XLEN  = 32;
  localparam int PCW   = 12;
  localparam int IMM_W = 17;
  localparam int TGT_W = 27;

  // field low-bit positions
  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam logic [4:0] RSTATUS = 5'd30;
  localparam logic [4:0] RA      = 5'd31;

  typedef struct packed {
    logic [4:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       shamt;
    logic [4:0]       aluop;
    logic [XLEN-1:0]  imm;   // sign-extended
    logic [TGT_W-1:0] tgt;
  } inst_t;

  function automatic inst_t decode(input logic [XLEN-1:0] w);
    inst_t d;
    d.op    = w[OP_LSB    +: 5];
    d.rd    = w[RD_LSB    +: 5];
    d.rs    = w[RS_LSB    +: 5];
    d.rt    = w[RT_LSB    +: 5];
    d.shamt = w[SHAMT_LSB +: 5];
    d.aluop = w[ALUOP_LSB +: 5];
    d.imm   = {{(XLEN-IMM_W){w[IMM_W-1]}}, w[IMM_W-1:0]};
    d.tgt   = w[TGT_W-1:0];
    return d;
  endfunction
endpackage

// File: rtl/regfile.sv
// dffe: W-bit register with async active-high clear and write enable.
//   clk, rst, en, d -> out
// regfile: 32x32 register file, 2 combinational read ports, 1 write port.
//   clk, rst, we, waddr, wdata, raddr_a/raddr_b -> rdata_a/rdata_b
//   r0 has no storage and always reads zero.
module dffe #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] out
);
  // power-up value lets the core run without ever seeing a reset pulse
  logic [W-1:0] q = '0;

  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (en) q <= d;

  assign out = q;
endmodule

module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:1] wen;
  logic [31:0] rf [32];

  always_comb begin
    wen = '0;
    for (int i = 1; i < 32; i++) wen[i] = we && (waddr == 5'(i));
  end

  assign rf[0] = '0;

  // explicit instances so each register is reachable as my_regfile.reg_N.out
  dffe reg_1  (.clk, .rst, .en(wen[1]),  .d(wdata), .out(rf[1]));
  dffe reg_2  (.clk, .rst, .en(wen[2]),  .d(wdata), .out(rf[2]));
  dffe reg_3  (.clk, .rst, .en(wen[3]),  .d(wdata), .out(rf[3]));
  dffe reg_4  (.clk, .rst, .en(wen[4]),  .d(wdata), .out(rf[4]));
  dffe reg_5  (.clk, .rst, .en(wen[5]),  .d(wdata), .out(rf[5]));
  dffe reg_6  (.clk, .rst, .en(wen[6]),  .d(wdata), .out(rf[6]));
  dffe reg_7  (.clk, .rst, .en(wen[7]),  .d(wdata), .out(rf[7]));
  dffe reg_8  (.clk, .rst, .en(wen[8]),  .d(wdata), .out(rf[8]));
  dffe reg_9  (.clk, .rst, .en(wen[9]),  .d(wdata), .out(rf[9]));
  dffe reg_10 (.clk, .rst, .en(wen[10]), .d(wdata), .out(rf[10]));
  dffe reg_11 (.clk, .rst, .en(wen[11]), .d(wdata), .out(rf[11]));
  dffe reg_12 (.clk, .rst, .en(wen[12]), .d(wdata), .out(rf[12]));
  dffe reg_13 (.clk, .rst, .en(wen[13]), .d(wdata), .out(rf[13]));
  dffe reg_14 (.clk, .rst, .en(wen[14]), .d(wdata), .out(rf[14]));
  dffe reg_15 (.clk, .rst, .en(wen[15]), .d(wdata), .out(rf[15]));
  dffe reg_16 (.clk, .rst, .en(wen[16]), .d(wdata), .out(rf[16]));
  dffe reg_17 (.clk, .rst, .en(wen[17]), .d(wdata), .out(rf[17]));
  dffe reg_18 (.clk, .rst, .en(wen[18]), .d(wdata), .out(rf[18]));
  dffe reg_19 (.clk, .rst, .en(wen[19]), .d(wdata), .out(rf[19]));
  dffe reg_20 (.clk, .rst, .en(wen[20]), .d(wdata), .out(rf[20]));
  dffe reg_21 (.clk, .rst, .en(wen[21]), .d(wdata), .out(rf[21]));
  dffe reg_22 (.clk, .rst, .en(wen[22]), .d(wdata), .out(rf[22]));
  dffe reg_23 (.clk, .rst, .en(wen[23]), .d(wdata), .out(rf[23]));
  dffe reg_24 (.clk, .rst, .en(wen[24]), .d(wdata), .out(rf[24]));
  dffe reg_25 (.clk, .rst, .en(wen[25]), .d(wdata), .out(rf[25]));
  dffe reg_26 (.clk, .rst, .en(wen[26]), .d(wdata), .out(rf[26]));
  dffe reg_27 (.clk, .rst, .en(wen[27]), .d(wdata), .out(rf[27]));
  dffe reg_28 (.clk, .rst, .en(wen[28]), .d(wdata), .out(rf[28]));
  dffe reg_29 (.clk, .rst, .en(wen[29]), .d(wdata), .out(rf[29]));
  dffe reg_30 (.clk, .rst, .en(wen[30]), .d(wdata), .out(rf[30]));
  dffe reg_31 (.clk, .rst, .en(wen[31]), .d(wdata), .out(rf[31]));

  assign rdata_a = rf[raddr_a];
  assign rdata_b = rf[raddr_b];
endmodule

// File: rtl/skeleton_top.sv
// Single-cycle 32-bit core: PC, instruction ROM, regfile, ALU, data RAM.
//   clock : system clock, all state updates on the rising edge
//   reset : async active-high, clears PC and r1..r31
// State is observed hierarchically (address_imem, q_imem, my_regfile.reg_N.out).
module skeleton_top
  import cpu_pkg::*;
#(
  parameter string IMEM_INIT  = "imem.hex",
  parameter int    IMEM_DEPTH = 4096,
  parameter int    DMEM_DEPTH = 4096
) (
  input logic clock,
  input logic reset
);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [PCW-1:0]  pc = '0;
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  wire [11:0] address_imem;
  wire [31:0] q_imem;

  inst_t           d;
  logic [4:0]      ra_addr, rb_addr, waddr;
  logic [XLEN-1:0] a, rb_data, b, sum, diff, wdata;
  logic            add_ovf, sub_ovf, we, dwe;
  logic [PCW-1:0]  pc_inc, pc_br, pc_next;
  logic [DAW-1:0]  daddr;

  assign address_imem = pc;
  assign q_imem       = imem[address_imem];
  assign d            = decode(q_imem);

  // port A: rs, or rstatus for bex; port B: rt for R-type, else rd
  assign ra_addr = (d.op == OP_BEX)   ? RSTATUS : d.rs;
  assign rb_addr = (d.op == OP_RTYPE) ? d.rt    : d.rd;

  regfile my_regfile (
    .clk(clock), .rst(reset),
    .we, .waddr, .wdata,
    .raddr_a(ra_addr), .raddr_b(rb_addr),
    .rdata_a(a), .rdata_b(rb_data)
  );

  assign b       = (d.op == OP_RTYPE) ? rb_data : d.imm;
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1]  != a[XLEN-1]);
  assign sub_ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
  assign daddr   = sum[DAW-1:0];
  assign dwe     = (d.op == OP_SW);
  assign pc_inc  = pc + PCW'(1);
  assign pc_br   = pc_inc + d.imm[PCW-1:0];

  always_comb begin
    we      = 1'b0;
    waddr   = d.rd;
    wdata   = sum;
    pc_next = pc_inc;
    case (d.op)
      OP_RTYPE: case (d.aluop)
        ALU_ADD: begin
          we = 1'b1;
          // overflow redirects the single write port to rstatus
          if (add_ovf) begin waddr = RSTATUS; wdata = XLEN'(1); end
        end
        ALU_SUB: begin
          we    = 1'b1;
          wdata = diff;
          if (sub_ovf) begin waddr = RSTATUS; wdata = XLEN'(3); end
        end
        ALU_AND: begin we = 1'b1; wdata = a & b; end
        ALU_OR:  begin we = 1'b1; wdata = a | b; end
        ALU_SLL: begin we = 1'b1; wdata = a << d.shamt; end
        ALU_SRA: begin we = 1'b1; wdata = $signed(a) >>> d.shamt; end
        default: ;
      endcase
      OP_ADDI: begin
        we = 1'b1;
        if (add_ovf) begin waddr = RSTATUS; wdata = XLEN'(2); end
      end
      OP_LW:   begin we = 1'b1; wdata = dmem[daddr]; end
      OP_J:    pc_next = d.tgt[PCW-1:0];
      OP_JAL: begin
        we      = 1'b1;
        waddr   = RA;
        wdata   = {{(XLEN-PCW){1'b0}}, pc_inc};
        pc_next = d.tgt[PCW-1:0];
      end
      OP_JR:   pc_next = rb_data[PCW-1:0];
      OP_BNE:  if (rb_data != a) pc_next = pc_br;
      OP_BLT:  if ($signed(rb_data) < $signed(a)) pc_next = pc_br;
      OP_SETX: begin
        we    = 1'b1;
        waddr = RSTATUS;
        wdata = {{(XLEN-TGT_W){1'b0}}, d.tgt};
      end
      OP_BEX:  if (a != '0) pc_next = d.tgt[PCW-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) pc <= '0;
    else       pc <= pc_next;

  always_ff @(posedge clock)
    if (dwe) dmem[daddr] <= rb_data;
endmodule

// File: tb/tb_skeleton_top.sv
// Directed-program bench for skeleton_top: loads small programs into the
// instruction ROM and checks PC / register / memory state after each step.
module tb_skeleton_top;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  skeleton_top #(.IMEM_INIT("")) dut (.clock(clock), .reset(reset));

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] f_i(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, rd, rs, v[16:0]};
  endfunction
  function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] sh,
                                      input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, sh, alu, 2'b00};
  endfunction
  function automatic logic [31:0] f_j(input logic [4:0] op, input int t);
    logic [31:0] v;
    v = t;
    return {op, v[26:0]};
  endfunction

  task automatic clr_imem;
    for (int i = 0; i < 4096; i++) dut.imem[i] = 32'h0;
  endtask
  task automatic put(input int a, input logic [31:0] w);
    dut.imem[a] = w;
  endtask
  task automatic start;
    @(negedge clock) reset = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic hold_reset;
    @(negedge clock) reset = 1'b1;
    #1;
    clr_imem();
  endtask

  initial begin
    // power-up state, no reset pulse
    clr_imem();
    put(0, f_i(5'b00101, 5'd1, 5'd0, 5));
    put(1, f_i(5'b00101, 5'd2, 5'd0, 3));
    #1;
    chk("pwrup_pc", 32'(dut.address_imem), 32'd0);
    step(2);
    chk("p1_r1", dut.my_regfile.reg_1.out, 32'd5);
    chk("p1_r2", dut.my_regfile.reg_2.out, 32'd3);
    chk("p1_pc", 32'(dut.address_imem), 32'd2);

    // async reset, visible before the next edge
    @(negedge clock) reset = 1'b1;
    #1;
    chk("arst_pc", 32'(dut.address_imem), 32'd0);
    chk("arst_r1", dut.my_regfile.reg_1.out, 32'd0);
    start();
    step(1);
    chk("rst_restart_pc", 32'(dut.address_imem), 32'd1);
    chk("rst_restart_r1", dut.my_regfile.reg_1.out, 32'd5);
    chk("rst_restart_r2", dut.my_regfile.reg_2.out, 32'd0);

    // overflow + logic/shift program
    hold_reset();
    put(0,  f_i(5'b00101, 5'd4, 5'd0, 1));          // r4 = 1
    put(1,  f_r(5'd4, 5'd4, 5'd0, 5'd31, 5'd4));    // r4 = 0x80000000
    put(2,  f_i(5'b00101, 5'd4, 5'd4, 1));          // r4 = 0x80000001
    put(3,  f_r(5'd1, 5'd0, 5'd4, 5'd0, 5'd1));     // r1 = 0 - r4 = 0x7FFFFFFF
    put(4,  f_i(5'b00101, 5'd3, 5'd0, 9));          // r3 = 9
    put(5,  f_r(5'd3, 5'd1, 5'd1, 5'd0, 5'd0));     // add ovf -> r30=1
    put(6,  f_i(5'b00101, 5'd6, 5'd1, 1));          // addi ovf -> r30=2
    put(7,  f_i(5'b00101, 5'd7, 5'd4, -1));         // r7 = 0x80000000
    put(8,  f_i(5'b00101, 5'd10, 5'd0, 1));         // r10 = 1
    put(9,  f_r(5'd8, 5'd7, 5'd10, 5'd0, 5'd1));    // sub ovf -> r30=3
    put(10, f_r(5'd30, 5'd1, 5'd1, 5'd0, 5'd0));    // rd=r30, ovf code wins
    put(11, f_r(5'd11, 5'd7, 5'd0, 5'd4, 5'd5));    // sra 4
    put(12, f_r(5'd12, 5'd1, 5'd7, 5'd0, 5'd2));    // and
    put(13, f_r(5'd13, 5'd1, 5'd7, 5'd0, 5'd3));    // or
    start();
    step(4);
    chk("ovf_r4", dut.my_regfile.reg_4.out, 32'h8000_0001);
    chk("ovf_r1", dut.my_regfile.reg_1.out, 32'h7FFF_FFFF);
    step(2);
    chk("add_ovf_r3", dut.my_regfile.reg_3.out, 32'd9);
    chk("add_ovf_r30", dut.my_regfile.reg_30.out, 32'd1);
    step(1);
    chk("addi_ovf_r30", dut.my_regfile.reg_30.out, 32'd2);
    chk("addi_ovf_r6", dut.my_regfile.reg_6.out, 32'd0);
    step(3);
    chk("neg_addi_r7", dut.my_regfile.reg_7.out, 32'h8000_0000);
    chk("sub_ovf_r30", dut.my_regfile.reg_30.out, 32'd3);
    chk("sub_ovf_r8", dut.my_regfile.reg_8.out, 32'd0);
    step(1);
    chk("ovf_rd30_r30", dut.my_regfile.reg_30.out, 32'd1);
    step(3);
    chk("sra_r11", dut.my_regfile.reg_11.out, 32'hF800_0000);
    chk("and_r12", dut.my_regfile.reg_12.out, 32'h0);
    chk("or_r13", dut.my_regfile.reg_13.out, 32'hFFFF_FFFF);

    // memory and r0
    hold_reset();
    put(0, f_i(5'b00101, 5'd1, 5'd0, 5));
    put(1, f_i(5'b00111, 5'd1, 5'd0, 4));           // sw r1,4(r0)
    put(2, f_i(5'b01000, 5'd2, 5'd0, 4));           // lw r2,4(r0)
    put(3, f_i(5'b00101, 5'd0, 5'd0, 7));           // addi r0,r0,7
    put(4, f_r(5'd3, 5'd0, 5'd1, 5'd0, 5'd0));      // r3 = r0 + r1
    start();
    step(2);
    chk("sw_dmem4", dut.dmem[4], 32'd5);
    step(3);
    chk("lw_r2", dut.my_regfile.reg_2.out, 32'd5);
    chk("r0_zero_r3", dut.my_regfile.reg_3.out, 32'd5);

    // jal / jr / j / bne / blt-not-taken
    hold_reset();
    put(0,  f_i(5'b00101, 5'd1, 5'd0, 5));
    put(1,  f_i(5'b00101, 5'd2, 5'd0, 3));
    put(3,  f_j(5'b00011, 10));                     // jal 10
    put(10, f_i(5'b00100, 5'd31, 5'd0, 0));         // jr r31
    put(4,  f_j(5'b00001, 6));                      // j 6
    put(6,  f_i(5'b00010, 5'd1, 5'd2, -2));         // bne r1,r2,-2
    put(5,  f_i(5'b00110, 5'd1, 5'd2, 20));         // blt 5<3 not taken
    start();
    step(4);
    chk("jal_r31", dut.my_regfile.reg_31.out, 32'd4);
    chk("jal_pc", 32'(dut.address_imem), 32'd10);
    step(1);
    chk("jr_pc", 32'(dut.address_imem), 32'd4);
    step(1);
    chk("j_pc", 32'(dut.address_imem), 32'd6);
    step(1);
    chk("bne_pc", 32'(dut.address_imem), 32'd5);
    step(1);
    chk("blt_nt_pc", 32'(dut.address_imem), 32'd6);

    // setx / bex / blt taken / bne not taken / PC wrap
    hold_reset();
    put(0,    f_j(5'b10101, 7));                    // setx 7
    put(1,    f_j(5'b10110, 20));                   // bex 20
    put(20,   f_i(5'b00101, 5'd1, 5'd0, -3));       // r1 = -3
    put(21,   f_i(5'b00110, 5'd1, 5'd0, 5));        // blt -3<0 taken -> 27
    put(27,   f_j(5'b10101, 0));                    // setx 0
    put(28,   f_j(5'b10110, 100));                  // bex not taken
    put(29,   f_i(5'b00010, 5'd0, 5'd0, 5));        // bne r0,r0 not taken
    put(30,   f_j(5'b00001, 4095));                 // j 4095
    start();
    step(1);
    chk("setx_r30", dut.my_regfile.reg_30.out, 32'd7);
    step(1);
    chk("bex_pc", 32'(dut.address_imem), 32'd20);
    step(1);
    chk("neg_r1", dut.my_regfile.reg_1.out, 32'hFFFF_FFFD);
    step(1);
    chk("blt_t_pc", 32'(dut.address_imem), 32'd27);
    step(1);
    chk("setx0_r30", dut.my_regfile.reg_30.out, 32'd0);
    step(1);
    chk("bex_nt_pc", 32'(dut.address_imem), 32'd29);
    step(1);
    chk("bne_nt_pc", 32'(dut.address_imem), 32'd30);
    step(1);
    chk("j_4095_pc", 32'(dut.address_imem), 32'd4095);
    step(1);
    chk("wrap_pc", 32'(dut.address_imem), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
